// File: rtl/button_pkg.sv
// Shared types and widths for the button event generator.
package button_pkg;

    typedef enum logic [1:0] {IDLE, HELD, REPEAT, LOCKOUT} btn_state_t;

    localparam int PRESS_COUNT_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/button_events.sv
// Turns a debounced button level into registered single-cycle events:
// press, release, short click, long press and hold-to-repeat.
module button_events
    import button_pkg::*;
#(
    parameter int LONG_CYCLES   = 100_000_000,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic                     clock_in,
    input  logic                     reset_in,
    input  logic                     clean_in,
    output logic                     press_out,
    output logic                     release_out,
    output logic                     short_out,
    output logic                     long_out,
    output logic                     repeat_out,
    output logic                     held_out,
    output logic [PRESS_COUNT_W-1:0] press_count_out
);

    localparam int CNT_W = $clog2(max3(LONG_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
    localparam logic [CNT_W-1:0] C_LONG    = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] C_RDLY    = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] C_RPER_M1 = CNT_W'(REPEAT_PERIOD - 1);

    btn_state_t               r_state, w_state;
    logic [CNT_W-1:0]         r_hold_cnt, w_hold_cnt, w_hold_inc;
    logic [CNT_W-1:0]         r_rep_cnt, w_rep_cnt, w_rep_inc;
    logic                     r_long_fired, w_long_fired;
    logic                     r_press, w_press;
    logic                     r_release, w_release;
    logic                     r_short, w_short;
    logic                     r_long, w_long;
    logic                     r_repeat, w_repeat;
    logic                     r_held, w_held;
    logic [PRESS_COUNT_W-1:0] r_press_count, w_press_count;

    always_comb begin
        w_state       = r_state;
        w_hold_cnt    = r_hold_cnt;
        w_rep_cnt     = r_rep_cnt;
        w_long_fired  = r_long_fired;
        w_press       = 1'b0;
        w_release     = 1'b0;
        w_short       = 1'b0;
        w_long        = 1'b0;
        w_repeat      = 1'b0;
        w_held        = r_held;
        w_press_count = r_press_count;
        w_hold_inc    = (r_hold_cnt == '1) ? r_hold_cnt : r_hold_cnt + CNT_W'(1);
        w_rep_inc     = (r_rep_cnt == '1) ? r_rep_cnt : r_rep_cnt + CNT_W'(1);

        case (r_state)
            LOCKOUT: begin
                if (!clean_in) w_state = IDLE;
            end
            IDLE: begin
                if (clean_in) begin
                    w_press       = 1'b1;
                    w_press_count = r_press_count + PRESS_COUNT_W'(1);
                    w_held        = 1'b1;
                    w_hold_cnt    = CNT_W'(1);
                    w_rep_cnt     = '0;
                    w_long_fired  = 1'b0;
                    w_state       = HELD;
                end
            end
            HELD, REPEAT: begin
                // Release is checked first so it suppresses any threshold on the same edge.
                if (!clean_in) begin
                    w_release    = 1'b1;
                    w_short      = ~r_long_fired;
                    w_held       = 1'b0;
                    w_long_fired = 1'b0;
                    w_hold_cnt   = '0;
                    w_rep_cnt    = '0;
                    w_state      = IDLE;
                end else begin
                    w_hold_cnt = w_hold_inc;
                    if (!r_long_fired && r_hold_cnt == C_LONG) begin
                        w_long       = 1'b1;
                        w_long_fired = 1'b1;
                    end
                    if (r_state == HELD) begin
                        if (REPEAT_DELAY != 0 && r_hold_cnt == C_RDLY) begin
                            w_repeat  = 1'b1;
                            w_rep_cnt = '0;
                            w_state   = REPEAT;
                        end
                    end else if (r_rep_cnt == C_RPER_M1) begin
                        w_repeat  = 1'b1;
                        w_rep_cnt = '0;
                    end else begin
                        w_rep_cnt = w_rep_inc;
                    end
                end
            end
            default: w_state = LOCKOUT;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            r_state       <= LOCKOUT;
            r_hold_cnt    <= '0;
            r_rep_cnt     <= '0;
            r_long_fired  <= 1'b0;
            r_press       <= 1'b0;
            r_release     <= 1'b0;
            r_short       <= 1'b0;
            r_long        <= 1'b0;
            r_repeat      <= 1'b0;
            r_held        <= 1'b0;
            r_press_count <= '0;
        end else begin
            r_state       <= w_state;
            r_hold_cnt    <= w_hold_cnt;
            r_rep_cnt     <= w_rep_cnt;
            r_long_fired  <= w_long_fired;
            r_press       <= w_press;
            r_release     <= w_release;
            r_short       <= w_short;
            r_long        <= w_long;
            r_repeat      <= w_repeat;
            r_held        <= w_held;
            r_press_count <= w_press_count;
        end
    end

    assign press_out       = r_press;
    assign release_out     = r_release;
    assign short_out       = r_short;
    assign long_out        = r_long;
    assign repeat_out      = r_repeat;
    assign held_out        = r_held;
    assign press_count_out = r_press_count;

endmodule

// File: tb/tb_button_events.sv
// Randomised and directed bench for button_events with a queue-based scoreboard.
module tb_button_events;

    localparam int LONG = 20;
    localparam int RD   = 8;
    localparam int RP   = 4;

    logic       clock_in = 1'b0;
    logic       reset_in;
    logic       clean_in;
    logic       press_out, release_out, short_out, long_out, repeat_out, held_out;
    logic [7:0] press_count_out;
    logic [13:0] act;

    button_events #(
        .LONG_CYCLES  (LONG),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clock_in       (clock_in),
        .reset_in       (reset_in),
        .clean_in       (clean_in),
        .press_out      (press_out),
        .release_out    (release_out),
        .short_out      (short_out),
        .long_out       (long_out),
        .repeat_out     (repeat_out),
        .held_out       (held_out),
        .press_count_out(press_count_out)
    );

    always #5 clock_in = ~clock_in;

    assign act = {press_out, release_out, short_out, long_out, repeat_out, held_out, press_count_out};

    logic [13:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a press is tracked from its start cycle; events follow from elapsed time.
    bit         m_locked = 1'b1;
    bit         m_track  = 1'b0;
    int         m_cyc    = 0;
    int         m_t0     = 0;
    logic [7:0] m_count  = 8'd0;

    function automatic logic [13:0] model_step(input logic c);
        logic p, r, s, l, rp, h;
        int   n;
        p = 0; r = 0; s = 0; l = 0; rp = 0; h = 0;
        n = m_cyc - m_t0;
        if (m_locked) begin
            if (!c) m_locked = 1'b0;
        end else if (!m_track) begin
            if (c) begin
                p = 1; h = 1;
                m_count = m_count + 8'd1;
                m_track = 1'b1;
                m_t0    = m_cyc;
            end
        end else if (c) begin
            h  = 1;
            l  = (n == LONG);
            rp = (RD != 0) && (n >= RD) && (((n - RD) % RP) == 0);
        end else begin
            r = 1;
            s = (n <= LONG);
            m_track = 1'b0;
        end
        m_cyc = m_cyc + 1;
        return {p, r, s, l, rp, h, m_count};
    endfunction

    task automatic check(input string name, input logic [13:0] got, input logic [13:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s t=%0t: got p/r/s/l/rp/h=%b count=%0d, want p/r/s/l/rp/h=%b count=%0d",
                     name, $time, got[13:8], got[7:0], want[13:8], want[7:0]);
        end
    endtask

    task automatic drive(input logic c, input logic r);
        @(negedge clock_in);
        clean_in = c;
        if (!r) begin
            if (reset_in) begin
                reset_in = 1'b0;
                #1;
                check("async_reset", act, 14'h0);
            end
            m_locked = 1'b1;
            m_track  = 1'b0;
            m_count  = 8'd0;
            exp_q.push_back(14'h0);
        end else begin
            reset_in = 1'b1;
            exp_q.push_back(model_step(c));
        end
    endtask

    task automatic run(input logic c, input int n);
        for (int i = 0; i < n; i++) drive(c, 1'b1);
    endtask

    // Monitor: compare every registered output word against the queued expectation.
    initial begin
        logic [13:0] e;
        forever begin
            @(posedge clock_in);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("scoreboard", act, e);
            end
        end
    end

    initial begin
        reset_in = 1'b0;
        clean_in = 1'b1;
        #1 check("reset_state", act, 14'h0);

        // Button held through reset: lockout, then a real press.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0);
        run(1'b1, 30); run(1'b0, 2);
        run(1'b1, 3);  run(1'b0, 2);

        // Short click, long hold with repeats, release on thresholds.
        run(1'b1, 5);  run(1'b0, 3);
        run(1'b1, 25); run(1'b0, 3);
        run(1'b1, 8);  run(1'b0, 2);
        run(1'b1, 20); run(1'b0, 2);
        run(1'b1, 21); run(1'b1, 0); run(1'b0, 1);
        run(1'b1, 12); run(1'b0, 1);
        run(1'b1, 1);  run(1'b0, 2);

        // Reset mid-hold, button still held afterwards.
        run(1'b1, 10);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0);
        run(1'b1, 5); run(1'b0, 1); run(1'b1, 3); run(1'b0, 2);

        // Counter wrap with one-cycle presses.
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b0);
        run(1'b0, 1);
        for (int i = 0; i < 256; i++) begin
            run(1'b1, 1);
            run(1'b0, 1);
        end
        @(posedge clock_in);
        #2;
        n_tests++;
        if (press_count_out !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d, want 0", press_count_out);
        end

        // Random holds, gaps and occasional resets.
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 19) == 0) begin
                for (int j = 0; j < 2; j++) drive(1'($urandom_range(0, 1)), 1'b0);
            end
            run(1'b1, $urandom_range(1, 30));
            run(1'b0, $urandom_range(1, 4));
        end

        @(posedge clock_in);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
